// File: rtl/core_bus_arbiter.sv
// Multi-port bus arbiter: grants one requester at a time onto a single memory
// port, with round-robin or fixed priority selection and a per-access timeout.
//
// state | meaning
// IDLE  | waiting for any request; grant chosen and command latched on exit
// BUSY  | memory request outstanding; timeout counter running
// RESP  | one-cycle o_ack to the granted port (with o_err on timeout)
module core_bus_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int NPORTS  = 3,
  parameter int RR      = 1,
  parameter int TIMEOUT = 255
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_clk_en,
  input  logic [NPORTS-1:0]      i_req,
  input  logic [NPORTS-1:0]      i_we,
  input  logic [NPORTS*AW-1:0]   i_addr,
  input  logic [NPORTS*DW-1:0]   i_wdata,
  input  logic [NPORTS*DW/8-1:0] i_be,
  output logic [NPORTS-1:0]      o_ack,
  output logic                   o_err,
  output logic [DW-1:0]          o_rdata,
  output logic                   o_stall,
  output logic                   o_mem_req,
  output logic                   o_mem_we,
  output logic [AW-1:0]          o_mem_addr,
  output logic [DW-1:0]          o_mem_wdata,
  output logic [DW/8-1:0]        o_mem_be,
  input  logic [DW-1:0]          i_mem_rdata,
  input  logic                   i_mem_ack
);

  localparam int BW = DW / 8;
  localparam int PW = $clog2(NPORTS);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t        state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] grant;
  logic [PW-1:0] pick;
  logic [PW-1:0] base;
  logic [15:0]   cnt;
  logic          found;
  int            idx;

  // Search upward from base with wrap; base is pinned to 0 for fixed priority.
  always_comb begin
    base  = (RR != 0) ? ptr : '0;
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NPORTS; i++) begin
      idx = int'(base) + i;
      if (idx >= NPORTS) idx = idx - NPORTS;
      if (!found && i_req[PW'(idx)]) begin
        found = 1'b1;
        pick  = PW'(idx);
      end
    end
  end

  assign o_stall = (state != IDLE);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      ptr         <= '0;
      grant       <= '0;
      cnt         <= '0;
      o_ack       <= '0;
      o_err       <= 1'b0;
      o_rdata     <= '0;
      o_mem_req   <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_mem_be    <= '0;
    end else if (i_clk_en) begin
      case (state)
        IDLE: begin
          if (found) begin
            grant       <= pick;
            ptr         <= (pick == PW'(NPORTS - 1)) ? '0 : pick + 1'b1;
            o_mem_req   <= 1'b1;
            o_mem_we    <= i_we[pick];
            o_mem_addr  <= i_addr[int'(pick)*AW +: AW];
            o_mem_wdata <= i_wdata[int'(pick)*DW +: DW];
            o_mem_be    <= i_be[int'(pick)*BW +: BW];
            cnt         <= '0;
            state       <= BUSY;
          end
        end
        BUSY: begin
          cnt <= cnt + 16'd1;
          // A memory ack in the final counted cycle takes precedence over the timeout.
          if (i_mem_ack) begin
            o_rdata   <= i_mem_rdata;
            o_mem_req <= 1'b0;
            o_ack     <= NPORTS'(1) << grant;
            state     <= RESP;
          end else if (cnt == TO_LAST) begin
            o_rdata   <= '0;
            o_mem_req <= 1'b0;
            o_err     <= 1'b1;
            o_ack     <= NPORTS'(1) << grant;
            state     <= RESP;
          end
        end
        RESP: begin
          o_ack <= '0;
          o_err <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Bench for core_bus_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level model of arbitration, latency and timeout.
module tb_core_bus_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int TO = 4;
  localparam int CW = 1 + AW + DW + BW;

  logic clk = 1'b0;
  logic rst, clk_en, mem_ack;
  logic [DW-1:0] mem_rdata;
  logic [N-1:0] req, we;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [N*BW-1:0] be;

  logic [N-1:0] a_ack, b_ack;
  logic a_err, b_err, a_stall, b_stall;
  logic [DW-1:0] a_rdata, b_rdata;
  logic a_mem_req, b_mem_req, a_mem_we, b_mem_we;
  logic [AW-1:0] a_mem_addr, b_mem_addr;
  logic [DW-1:0] a_mem_wdata, b_mem_wdata;
  logic [BW-1:0] a_mem_be, b_mem_be;

  bit pend[N];
  logic c_we[N];
  logic [AW-1:0] c_addr[N];
  logic [DW-1:0] c_wdata[N];
  logic [BW-1:0] c_be[N];

  int n_chk = 0;
  int n_fail = 0;
  int ptr_m;
  logic [DW-1:0] last_rd;
  bit rd_known;

  always #5 clk = ~clk;

  always_comb begin
    req = '0; we = '0; addr = '0; wdata = '0; be = '0;
    for (int i = 0; i < N; i++) begin
      req[i] = pend[i];
      we[i] = c_we[i];
      addr[i*AW +: AW] = c_addr[i];
      wdata[i*DW +: DW] = c_wdata[i];
      be[i*BW +: BW] = c_be[i];
    end
  end

  core_bus_arbiter #(.AW(AW), .DW(DW), .NPORTS(N), .RR(1), .TIMEOUT(TO)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_clk_en(clk_en), .i_req(req), .i_we(we),
    .i_addr(addr), .i_wdata(wdata), .i_be(be), .o_ack(a_ack), .o_err(a_err),
    .o_rdata(a_rdata), .o_stall(a_stall), .o_mem_req(a_mem_req), .o_mem_we(a_mem_we),
    .o_mem_addr(a_mem_addr), .o_mem_wdata(a_mem_wdata), .o_mem_be(a_mem_be),
    .i_mem_rdata(mem_rdata), .i_mem_ack(mem_ack));

  core_bus_arbiter #(.AW(AW), .DW(DW), .NPORTS(N), .RR(0)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_clk_en(clk_en), .i_req(req), .i_we(we),
    .i_addr(addr), .i_wdata(wdata), .i_be(be), .o_ack(b_ack), .o_err(b_err),
    .o_rdata(b_rdata), .o_stall(b_stall), .o_mem_req(b_mem_req), .o_mem_we(b_mem_we),
    .o_mem_addr(b_mem_addr), .o_mem_wdata(b_mem_wdata), .o_mem_be(b_mem_be),
    .i_mem_rdata(mem_rdata), .i_mem_ack(mem_ack));

  wire [CW-1:0] a_cmd = {a_mem_we, a_mem_addr, a_mem_wdata, a_mem_be};
  wire [CW-1:0] b_cmd = {b_mem_we, b_mem_addr, b_mem_wdata, b_mem_be};

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] oh(input int p);
    return N'(1) << p;
  endfunction

  function automatic logic [CW-1:0] cmd_of(input int p);
    return {c_we[p], c_addr[p], c_wdata[p], c_be[p]};
  endfunction

  function automatic int pick_rr();
    for (int i = 0; i < N; i++)
      if (pend[(ptr_m + i) % N]) return (ptr_m + i) % N;
    return -1;
  endfunction

  function automatic int pick_lo();
    for (int i = 0; i < N; i++)
      if (pend[i]) return i;
    return -1;
  endfunction

  task automatic new_cmd(input int p);
    c_we[p] = 1'($urandom_range(0, 1));
    c_addr[p] = $urandom;
    c_wdata[p] = $urandom;
    c_be[p] = 4'($urandom_range(0, 15));
    pend[p] = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clk_en = 1'b0;
    mem_ack = 1'b0;
    tick();
    rst = 1'b0;
    clk_en = 1'b1;
    ptr_m = 0;
    last_rd = '0;
    rd_known = 1'b1;
  endtask

  task automatic idle_tick();
    mem_ack = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    tick();
    mem_ack = 1'b0;
    check("idle_stall", a_stall, 1'b0);
    check("idle_mem_req", a_mem_req, 1'b0);
    check("idle_ack", a_ack, '0);
    if (rd_known) check("idle_rdata_hold", a_rdata, last_rd);
  endtask

  // Called in an IDLE cycle with at least one port pending; returns in the
  // next IDLE cycle after the response.
  task automatic run_txn(input int delay, input int frz_at, input int frz_len, input bit drop,
                         input bit chk_b, input logic [DW-1:0] rd_val, output logic [N-1:0] ack_seen);
    int g, gb, n;
    bit done, is_rd, en, ack;
    logic [CW-1:0] exp_cmd, exp_b;
    logic [DW-1:0] exp_rd;
    ack_seen = '0;
    exp_rd = '0;
    g = pick_rr();
    gb = pick_lo();
    if (g < 0) begin
      check("txn_has_pending", 1'b0, 1'b1);
      return;
    end
    exp_cmd = cmd_of(g);
    exp_b = cmd_of(gb);
    is_rd = !c_we[g];
    tick();
    check("busy_entry_req", a_mem_req, 1'b1);
    check("busy_entry_stall", a_stall, 1'b1);
    check("grant_cmd", a_cmd, exp_cmd);
    if (chk_b) check("fixed_prio_cmd", b_cmd, exp_b);
    ptr_m = (g + 1) % N;
    // The granted port's inputs move while the access is outstanding.
    c_addr[g] = $urandom;
    c_wdata[g] = $urandom;
    c_be[g] = ~c_be[g];
    c_we[g] = ~c_we[g];
    n = 0;
    done = 1'b0;
    for (int k = 0; k < 64 && !done; k++) begin
      en = !(k >= frz_at && k < frz_at + frz_len);
      ack = en && (n == delay);
      clk_en = en;
      mem_ack = ack || !en;
      mem_rdata = ack ? rd_val : $urandom;
      if (ack) exp_rd = rd_val;
      tick();
      mem_ack = 1'b0;
      clk_en = 1'b1;
      if (en) n++;
      if (ack) begin
        ack_seen = a_ack;
        check("resp_ack", a_ack, oh(g));
        check("resp_err", a_err, 1'b0);
        check("resp_mem_req", a_mem_req, 1'b0);
        if (is_rd) check("resp_rdata", a_rdata, exp_rd);
        if (chk_b) begin
          check("fixed_prio_ack", b_ack, oh(gb));
          check("fixed_prio_err", b_err, 1'b0);
        end
        rd_known = is_rd;
        last_rd = exp_rd;
        done = 1'b1;
      end else if (en && n == TO) begin
        ack_seen = a_ack;
        check("timeout_ack", a_ack, oh(g));
        check("timeout_err", a_err, 1'b1);
        check("timeout_rdata", a_rdata, '0);
        check("timeout_mem_req", a_mem_req, 1'b0);
        rd_known = 1'b1;
        last_rd = '0;
        done = 1'b1;
      end else begin
        check("busy_mem_req", a_mem_req, 1'b1);
        check("busy_ack", a_ack, '0);
        check("busy_cmd_stable", a_cmd, exp_cmd);
      end
    end
    check("txn_completed", done, 1'b1);
    if (drop) pend[g] = 1'b0;
    mem_ack = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    tick();
    mem_ack = 1'b0;
    check("post_ack", a_ack, '0);
    check("post_err", a_err, 1'b0);
    check("post_stall", a_stall, 1'b0);
    check("post_mem_req", a_mem_req, 1'b0);
    if (rd_known) check("post_rdata_hold", a_rdata, last_rd);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] seen;
    mem_rdata = '0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0; c_we[i] = 1'b0; c_addr[i] = '0; c_wdata[i] = '0; c_be[i] = '0;
    end
    do_reset();
    do_reset();
    check("reset_ack", a_ack, '0);
    check("reset_err", a_err, 1'b0);
    check("reset_rdata", a_rdata, '0);
    check("reset_stall", a_stall, 1'b0);
    check("reset_mem_req", a_mem_req, 1'b0);
    check("reset_cmd", a_cmd, '0);

    // Single read from port 1.
    c_we[1] = 1'b0; c_addr[1] = 32'h40; c_wdata[1] = '0; c_be[1] = 4'hF; pend[1] = 1'b1;
    run_txn(2, 99, 0, 1'b1, 1'b0, 32'hDEADBEEF, seen);
    check("single_read_ack", seen, 3'b010);
    check("single_read_rdata", a_rdata, 32'hDEADBEEF);

    // Write from port 2.
    c_we[2] = 1'b1; c_addr[2] = 32'h1000; c_wdata[2] = 32'h11223344; c_be[2] = 4'b0101; pend[2] = 1'b1;
    run_txn(1, 99, 0, 1'b1, 1'b0, 32'hCAFEF00D, seen);
    check("write_ack", seen, 3'b100);

    // Timeout, then an ack in the last counted cycle.
    new_cmd(0); c_we[0] = 1'b0;
    run_txn(99, 99, 0, 1'b1, 1'b0, '0, seen);
    check("timeout_seen", seen, 3'b001);
    new_cmd(0); c_we[0] = 1'b0;
    run_txn(TO - 1, 99, 0, 1'b1, 1'b0, 32'h5A5A0001, seen);
    check("late_ack_seen", seen, 3'b001);

    // Round-robin with all ports requesting continuously.
    do_reset();
    for (int p = 0; p < N; p++) new_cmd(p);
    for (int t = 0; t < 6; t++) begin
      run_txn(0, 99, 0, 1'b0, 1'b1, $urandom, seen);
      check("rr_order", seen, oh(t % 3));
    end

    // Ports 0 and 2 continuous: round-robin alternates, fixed priority starves 2.
    do_reset();
    for (int p = 0; p < N; p++) pend[p] = 1'b0;
    new_cmd(0); new_cmd(2);
    for (int t = 0; t < 4; t++) begin
      run_txn(0, 99, 0, 1'b0, 1'b1, $urandom, seen);
      check("rr_skip_order", seen, (t % 2 == 0) ? oh(0) : oh(2));
    end

    // Clock-enable freeze mid-access, then reset during an access.
    do_reset();
    for (int p = 0; p < N; p++) pend[p] = 1'b0;
    new_cmd(1);
    run_txn(1, 1, 5, 1'b1, 1'b0, $urandom, seen);
    check("freeze_ack", seen, 3'b010);
    new_cmd(0);
    tick();
    check("pre_reset_busy", a_mem_req, 1'b1);
    rst = 1'b1; clk_en = 1'b0; pend[0] = 1'b0;
    tick();
    check("reset_busy_mem_req", a_mem_req, 1'b0);
    check("reset_busy_stall", a_stall, 1'b0);
    check("reset_busy_ack", a_ack, '0);
    rst = 1'b0; clk_en = 1'b1;
    ptr_m = 0; last_rd = '0; rd_known = 1'b1;
    idle_tick();

    // Randomized traffic.
    for (int it = 0; it < 200; it++) begin
      int dly, fa, fl;
      bit any;
      any = 1'b0;
      for (int p = 0; p < N; p++) any |= pend[p];
      if (!any) begin
        for (int j = 0; j < $urandom_range(1, 3); j++) idle_tick();
        new_cmd($urandom_range(0, N - 1));
      end
      for (int p = 0; p < N; p++)
        if (!pend[p] && $urandom_range(0, 2) == 0) new_cmd(p);
      dly = $urandom_range(0, 5);
      fa = $urandom_range(0, 3);
      fl = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 4) : 0;
      run_txn(dly, fa, fl, $urandom_range(0, 3) != 0, 1'b0, $urandom, seen);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/core_bus_arbiter.md
CORE_BUS_ARBITER -- requirements
Module: core_bus_arbiter

Interface
REQ-001 SHALL have parameter AW, default 32, address width.
REQ-002 SHALL have parameter DW, default 32, data width, multiple of 8.
REQ-003 SHALL have parameter NPORTS, default 3, requester count, range 2..8.
REQ-004 SHALL have parameter RR, default 1; 1 = round-robin, 0 = fixed priority with lowest index winning.
REQ-005 SHALL have parameter TIMEOUT, default 255, maximum BUSY cycles before error, range 1..65535.
REQ-006 SHALL have port i_clk, input, 1, sole clock, rising edge.
REQ-007 SHALL have port i_rst, input, 1, reset, synchronous and active-high.
REQ-008 SHALL have port i_clk_en, input, 1, global clock enable.
REQ-009 SHALL have port i_req, input, NPORTS, per-port request.
REQ-010 SHALL have port i_we, input, NPORTS, per-port write flag.
REQ-011 SHALL have port i_addr, input, NPORTS*AW, packed addresses, port p at bits [p*AW +: AW].
REQ-012 SHALL have port i_wdata, input, NPORTS*DW, packed write data.
REQ-013 SHALL have port i_be, input, NPORTS*DW/8, packed byte enables.
REQ-014 SHALL have port o_ack, output, NPORTS, one-hot completion pulse.
REQ-015 SHALL have port o_err, output, 1, timeout flag qualifying o_ack.
REQ-016 SHALL have port o_rdata, output, DW, shared read data.
REQ-017 SHALL have port o_stall, output, 1, arbiter busy.
REQ-018 SHALL have ports o_mem_req/o_mem_we, outputs, 1 each, memory request and write flag.
REQ-019 SHALL have ports o_mem_addr (AW), o_mem_wdata (DW), o_mem_be (DW/8), outputs, memory command.
REQ-020 SHALL have ports i_mem_rdata (DW) and i_mem_ack (1), inputs, memory response.

Function
REQ-021 SHALL implement FSM states IDLE, BUSY and RESP; every register update SHALL be gated by i_clk_en, with state and outputs frozen while i_clk_en=0.
REQ-022 In IDLE with any i_req set, SHALL select grant g, latch port g's we/addr/wdata/be into the o_mem_* registers, and enter BUSY; o_mem_req SHALL rise on the next enabled edge.
REQ-023 With RR=0, g SHALL be the lowest set index.
REQ-024 With RR=1, g SHALL be the first set index at or after pointer ptr, searching upward with wrap; on each grant, ptr SHALL become (g+1) mod NPORTS.
REQ-025 In BUSY, o_mem_req and the command SHALL hold stable until i_mem_ack=1; then o_rdata SHALL capture i_mem_rdata, o_mem_req SHALL clear, and the FSM SHALL enter RESP.
REQ-026 In RESP, o_ack[g] SHALL be 1 for exactly one enabled cycle, then the FSM SHALL enter IDLE.
REQ-027 o_rdata SHALL be valid while o_ack is high and SHALL hold its value until the next capture; it is undefined for writes.
REQ-028 Latency: a request seen in IDLE at cycle t with memory ack at cycle k≥t+1 SHALL produce o_ack at k+1; the minimum turnaround is 3 cycles.
REQ-029 i_mem_ack SHALL be ignored outside BUSY.
REQ-030 A requester SHALL hold i_req and its command until o_ack; i_req still set in the IDLE cycle after RESP SHALL be treated as a new request.
REQ-031 Requests from non-granted ports SHALL wait without loss; changes on the granted port's inputs during BUSY SHALL have no effect.
REQ-032 A 16-bit counter SHALL clear on BUSY entry and increment each BUSY cycle; reaching TIMEOUT without i_mem_ack SHALL clear o_mem_req, zero o_rdata, and enter RESP with o_err=1 alongside o_ack.
REQ-033 An i_mem_ack in the same cycle the count reaches TIMEOUT SHALL win, with o_err=0.
REQ-034 o_stall SHALL equal (state != IDLE), driven combinationally from state.

Reset
REQ-035 On i_rst=1 at an edge, regardless of i_clk_en, SHALL set state=IDLE, ptr=0, counter=0, and o_ack, o_err, o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be and o_rdata all to 0.
REQ-036 Reset during BUSY or RESP SHALL abandon the transaction with no o_ack issued.

Verification
REQ-037 Single read: port1 requests addr 0x40, memory acks 2 cycles after o_mem_req with rdata 0xDEADBEEF -> o_ack=3'b010 one cycle later, o_rdata=0xDEADBEEF, o_err=0.
REQ-038 Round-robin fairness (RR=1): ports 0, 1 and 2 request continuously with 1-cycle memory ack -> grants 0,1,2,0,1,2 and every port acked within 3 transactions.
REQ-039 Fixed priority (RR=0): ports 0 and 2 request continuously -> port 0 is always granted and port 2 starves.
REQ-040 Write: port2 writes wdata 0x11223344 with be 4'b0101 -> o_mem_we=1, o_mem_be=4'b0101 and o_mem_wdata held stable until ack.
REQ-041 Timeout (TIMEOUT=4): no i_mem_ack -> o_ack and o_err pulse together after 4 BUSY cycles, o_rdata=0; an ack in the 4th cycle instead gives o_err=0.
REQ-042 Freeze and reset: i_clk_en=0 for 5 cycles mid-BUSY -> outputs unchanged; i_rst asserted in BUSY -> next cycle IDLE, o_mem_req=0 and no o_ack.
